regfile_writeback: RTL and testbench

- Parametrised register-file writeback unit; successor of the separate GPR/FPR write blocks.
- Owns NREG x XLEN architectural registers.
- Commits results from two sources: a compute path with configurable latency, and a load path that waits for memory.
- Sits between the execute/memory stages and operand read; pulses wr_finish once per committed write.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_delay_line.sv | 45 ++++
 rtl/regfile_writeback.sv | 160 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and limits for the register-file writeback unit.
package wb_pkg;

  localparam int XLEN_D       = 32;
  localparam int NREG_D       = 32;
  localparam int AW_D         = $clog2(NREG_D);
  localparam int CALC_LAT_MAX = 7;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LOADWAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [AW_D-1:0]   addr;
    logic [XLEN_D-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-latency valid+payload shift pipe, LAT register stages (LAT=0 is a wire).
// No backpressure: every accepted entry emerges exactly LAT cycles later.
module wb_delay_line
  import wb_pkg::*;
#(
  parameter int  LAT = 1,
  parameter type T   = wb_req_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic vld_i,
  input  T     dat_i,
  output logic vld_o,
  output T     dat_o,
  output logic busy_o
);

  if (LAT == 0) begin : g_wire
    assign vld_o  = vld_i;
    assign dat_o  = dat_i;
    assign busy_o = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q;
    T               dat_q [LAT];

    always_ff @(posedge clk) begin
      if (!rstn) begin
        vld_q <= '0;
        for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        dat_q[0] <= dat_i;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign vld_o  = vld_q[LAT-1];
    assign dat_o  = dat_q[LAT-1];
    assign busy_o = |vld_q;
  end

endmodule

// File: rtl/regfile_writeback.sv
// NREG x XLEN register file committing compute (CALC_LAT cycles) and load results, one write per cycle.
// Load wins the write port; a colliding compute entry waits one cycle in a skid buffer. Optional WB_SCOREBOARD_EN adds pending bits.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int CALC_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     calc_valid,
  input  logic [$clog2(NREG)-1:0]  calc_addr,
  input  logic [XLEN-1:0]          calc_data,
  input  logic                     ld_valid,
  input  logic [$clog2(NREG)-1:0]  ld_addr,
  input  logic                     load_finish,
  input  logic [XLEN-1:0]          rdata,
  output logic [NREG*XLEN-1:0]     regs,
  output logic                     wr_finish,
  output logic                     busy
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [NREG-1:0]          pending
`endif
);

  localparam int AW  = $clog2(NREG);
  localparam int LAT = (CALC_LAT > CALC_LAT_MAX) ? CALC_LAT_MAX : CALC_LAT;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } req_t;

  wb_state_e                  state_q, state_d;
  logic [AW-1:0]              ld_addr_q, ld_addr_d;
  logic [NREG-1:0][XLEN-1:0]  regs_q;
  logic                       skid_vld_q, skid_vld_d;
  req_t                       skid_q, skid_d;
  logic                       wr_finish_q;

  req_t calc_req, arr, cmt;
  logic arr_vld, dl_busy, load_commit, cmt_vld, cmt_we;

  assign calc_req.addr = calc_addr;
  assign calc_req.data = calc_data;

  wb_delay_line #(
    .LAT (LAT),
    .T   (req_t)
  ) u_delay_line (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (calc_valid),
    .dat_i  (calc_req),
    .vld_o  (arr_vld),
    .dat_o  (arr),
    .busy_o (dl_busy)
  );

  // A second ld_valid while armed is ignored so the first destination survives.
  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    load_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          state_d   = LOADWAIT;
          ld_addr_d = ld_addr;
        end
      end
      LOADWAIT: begin
        if (load_finish) begin
          load_commit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    cmt_vld    = 1'b0;
    cmt        = '0;
    if (load_commit) begin
      cmt_vld  = 1'b1;
      cmt.addr = ld_addr_q;
      cmt.data = rdata;
      if (arr_vld) begin
        skid_vld_d = 1'b1;
        skid_d     = arr;
      end
    end else if (skid_vld_q) begin
      cmt_vld    = 1'b1;
      cmt        = skid_q;
      skid_vld_d = arr_vld;
      skid_d     = arr;
    end else if (arr_vld) begin
      cmt_vld = 1'b1;
      cmt     = arr;
    end
    cmt_we = cmt_vld && !((ZERO_REG != 0) && (cmt.addr == '0));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ld_addr_q   <= '0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      wr_finish_q <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      wr_finish_q <= cmt_vld;
      if (cmt_we) regs_q[cmt.addr] <= cmt.data;
    end
  end

  assign regs      = regs_q;
  assign wr_finish = wr_finish_q;
  assign busy      = (state_q == LOADWAIT) || dl_busy || skid_vld_q;

`ifdef WB_SCOREBOARD_EN
  // Count rather than flag: two writes to one register can be in flight at once.
  logic [NREG-1:0][2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREG; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (calc_valid && (calc_addr == AW'(i)))
          cnt_d[i] = cnt_d[i] + 3'd1;
        if ((state_q == IDLE) && ld_valid && (ld_addr == AW'(i)))
          cnt_d[i] = cnt_d[i] + 3'd1;
      end
      if (cmt_we && (cmt.addr == AW'(i)))
        cnt_d[i] = cnt_d[i] - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < NREG; g++) begin : g_pend
    assign pending[g] = |cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench: stimulus pushes expected commits; a monitor pops one per wr_finish pulse.
// Build with WB_SCOREBOARD_EN defined to also cover the pending bits.
module tb_regfile_writeback;
  import wb_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  calc_valid = 1'b0;
  logic [AW-1:0]         calc_addr = '0;
  logic [XLEN-1:0]       calc_data = '0;
  logic                  ld_valid = 1'b0;
  logic [AW-1:0]         ld_addr = '0;
  logic                  load_finish = 1'b0;
  logic [XLEN-1:0]       rdata = '0;
  logic [NREG*XLEN-1:0]  regs;
  logic                  wr_finish;
  logic                  busy;
`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0]       pending;
`endif

  int checks = 0;
  int passed = 0;
  wb_req_t exp_q[$];
  logic [XLEN-1:0] model [NREG];

  regfile_writeback #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .CALC_LAT (1),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .calc_valid  (calc_valid),
    .calc_addr   (calc_addr),
    .calc_data   (calc_data),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .load_finish (load_finish),
    .rdata       (rdata),
    .regs        (regs),
    .wr_finish   (wr_finish),
    .busy        (busy)
`ifdef WB_SCOREBOARD_EN
    ,
    .pending     (pending)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] reg_at(int i);
    return regs[i*XLEN +: XLEN];
  endfunction

  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_regs(string name);
    int bad;
    bad = -1;
    for (int i = 0; i < NREG; i++)
      if (bad < 0 && reg_at(i) !== model[i]) bad = i;
    checks++;
    if (bad < 0) passed++;
    else $display("FAIL %s: r%0d got %h expected %h", name, bad, reg_at(bad), model[bad]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_commit(logic [AW-1:0] a, logic [XLEN-1:0] d);
    wb_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_calc(logic [AW-1:0] a, logic [XLEN-1:0] d);
    calc_valid = 1'b1;
    calc_addr  = a;
    calc_data  = d;
  endtask

  // Monitor: each wr_finish cycle must match the oldest outstanding expectation.
  initial begin
    wb_req_t e;
    forever begin
      @(negedge clk);
      if (rstn && wr_finish) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL wr_finish_unexpected: got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("commit_r%0d", e.addr), reg_at(int'(e.addr)), e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      assert (!(ld_valid && dut.state_q == LOADWAIT))
        else $error("FAIL ld_protocol: ld_valid=1 while armed, required 0");
      assert (!(dut.load_commit && dut.arr_vld && dut.skid_vld_q))
        else $error("FAIL skid_overflow: skid full with load commit and new arrival");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset state
    tick();
    tick();
    chk_regs("reset_regs");
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_finish", 32'(wr_finish), 32'd0);
    rstn = 1'b1;

    // Single compute write, CALC_LAT=1
    expect_commit(5'd5, 32'hDEADBEEF);
    drive_calc(5'd5, 32'hDEADBEEF);
    tick();
    calc_valid = 1'b0;
    chk("busy_calc_inflight", 32'(busy), 32'd1);
    tick();
    tick();
    model[5] = 32'hDEADBEEF;
    chk_regs("after_calc");

    // Load with a 4-cycle memory wait
    ld_addr  = 5'd7;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_loadwait_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    expect_commit(5'd7, 32'h12345678);
    load_finish = 1'b1;
    rdata       = 32'h12345678;
    tick();
    load_finish = 1'b0;
    chk("busy_after_load", 32'(busy), 32'd0);
    tick();
    model[7] = 32'h12345678;
    chk_regs("after_load");

    // load_finish while idle is ignored
    load_finish = 1'b1;
    rdata       = 32'hCAFEF00D;
    tick();
    load_finish = 1'b0;
    tick();
    tick();
    chk_regs("idle_load_finish");

    // Load and compute commit to r3 on the same edge
    ld_addr  = 5'd3;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick();
    expect_commit(5'd3, 32'hAAAA0000);
    expect_commit(5'd3, 32'h00005555);
    drive_calc(5'd3, 32'h00005555);
    tick();
    calc_valid  = 1'b0;
    load_finish = 1'b1;
    rdata       = 32'hAAAA0000;
    tick();
    load_finish = 1'b0;
    chk("busy_skid", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    model[3] = 32'h00005555;
    chk_regs("after_collision");

    // Write to hardwired-zero register
    expect_commit(5'd0, 32'h0);
    drive_calc(5'd0, 32'hFFFFFFFF);
    tick();
    calc_valid = 1'b0;
    tick();
    tick();
    chk_regs("zero_reg");

    // Back-to-back compute writes to different registers
    expect_commit(5'd1, 32'h11111111);
    expect_commit(5'd2, 32'h22222222);
    drive_calc(5'd1, 32'h11111111);
    tick();
    drive_calc(5'd2, 32'h22222222);
    tick();
    calc_valid = 1'b0;
    tick();
    tick();
    model[1] = 32'h11111111;
    model[2] = 32'h22222222;
    chk_regs("back_to_back");

    // Two in-flight writes to r9
    expect_commit(5'd9, 32'h0000000A);
    expect_commit(5'd9, 32'h0000000B);
    drive_calc(5'd9, 32'h0000000A);
    tick();
`ifdef WB_SCOREBOARD_EN
    chk("pend9_first", 32'(pending[9]), 32'd1);
`endif
    drive_calc(5'd9, 32'h0000000B);
    tick();
    calc_valid = 1'b0;
`ifdef WB_SCOREBOARD_EN
    chk("pend9_overlap", 32'(pending[9]), 32'd1);
`endif
    tick();
`ifdef WB_SCOREBOARD_EN
    chk("pend9_clear", 32'(pending[9]), 32'd0);
    chk("pend_all_clear", 32'(pending), 32'd0);
`endif
    tick();
    model[9] = 32'h0000000B;
    chk_regs("same_addr_pair");

    // Reset while a load is armed and a compute write is in flight
    ld_addr  = 5'd10;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    drive_calc(5'd11, 32'h00000BAD);
    tick();
    calc_valid = 1'b0;
    rstn       = 1'b0;
    tick();
    chk("rst_wr_finish", 32'(wr_finish), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn        = 1'b1;
    load_finish = 1'b1;
    rdata       = 32'h77777777;
    tick();
    load_finish = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    chk_regs("after_reset_loadwait");
    chk("busy_after_reset", 32'(busy), 32'd0);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
